// File: rtl/uart_modport.sv
// uart_modport: 8N1 UART transmitter and receiver sharing one clock.
// TX and RX are independent two-process FSMs. RX input is double-flopped
// before use and sampled at mid-bit, with the timing measured from the start edge.
module uart_modport #(
  parameter int ClksPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       tx_idle_o,
  output logic       rx_idle_o
);

  // The counter width holds ClksPerBit-1, so it never wraps inside a bit.
  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  // The stop bit spends its final cycle in IDLE so a back-to-back byte starts without a gap.
  localparam logic [CntW-1:0] StopLast = CntW'(ClksPerBit - 2);
  // The mid-start sample lands ClksPerBit/2 cycles after the falling edge was seen.
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntZero  = CntW'(0);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // ---------------------------------------------------------------- TX
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;

  // TX state and datapath registers, reset to an idle-high line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CntZero;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state: serialise start, 8 data bits LSB first, then the stop bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid_i) begin
          tx_state_d = TX_START;
          tx_cnt_d   = CntZero;
          tx_bit_d   = 3'd0;
          tx_shift_d = tx_data_i;
          tx_line_d  = 1'b0;
        end else begin
          tx_line_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = CntZero;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d   = tx_cnt_q + CntOne;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = CntZero;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntOne;
        end
      end
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (tx_cnt_q == StopLast) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = CntZero;
        end else begin
          tx_cnt_d   = tx_cnt_q + CntOne;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CntZero;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  assign uart_tx_o  = tx_line_q;
  assign tx_idle_o  = (tx_state_q == TX_IDLE);
  assign tx_ready_o = tx_idle_o;

  // ---------------------------------------------------------------- RX
  logic [1:0]      rx_sync_q;
  logic            rx_s;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_brk_q, rx_brk_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;

  // Two-flop synchronizer for the asynchronous serial input, idle high.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx_i};
    end
  end

  assign rx_s = rx_sync_q[1];

  // RX state, datapath and output-pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CntZero;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_brk_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // RX next state: qualify the start bit, sample 8 data bits and the stop bit at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CntZero;
          rx_bit_d   = 3'd0;
        end else begin
          rx_cnt_d   = CntZero;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d = CntZero;
          if (rx_s) begin
            rx_state_d = RX_IDLE;   // start bit did not hold: glitch
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = CntZero;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
            rx_bit_d   = 3'd0;
          end else begin
            rx_bit_d   = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RX_STOP: begin
        if (rx_brk_q) begin
          // After a framing error, wait for the line to return high.
          if (rx_s) begin
            rx_state_d = RX_IDLE;
            rx_brk_d   = 1'b0;
          end else begin
            rx_brk_d   = 1'b1;
          end
        end else if (rx_cnt_q == BitLast) begin
          rx_cnt_d = CntZero;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d   = 1'b1;
            rx_brk_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CntZero;
        rx_brk_d   = 1'b0;
      end
    endcase
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_err_q;
  assign rx_idle_o      = (rx_state_q == RX_IDLE);

endmodule

// File: tb/tb_uart_modport.sv
// tb_uart_modport: table-driven RX vectors with a pulse scoreboard, plus
// hand-written TX waveform, glitch, framing-error, loopback and reset sequences.
module tb_uart_modport;
  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       rx_line;
  logic       rx_drv;
  logic       loop_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       tx_idle;
  logic       rx_idle;

  int vec_count  = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       err;
    logic [7:0] exp_data;
  } rx_vec_t;
  rx_vec_t vecs[6];

  assign rx_line = loop_en ? uart_tx : rx_drv;

  uart_modport #(.ClksPerBit(Cpb)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .uart_tx_o      (uart_tx),
    .uart_rx_i      (rx_line),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_frame_err_o (rx_err),
    .tx_idle_o      (tx_idle),
    .rx_idle_o      (rx_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      rx_drv = 1'b0;
      else if (i == 9) rx_drv = stop;
      else             rx_drv = d[i-1];
      repeat (Cpb) tick();
    end
    rx_drv = 1'b1;
  endtask

  // Scoreboard monitor: every rx pulse must match the oldest expected entry.
  always @(negedge clk) begin
    sb_t e;
    if (rx_valid === 1'b1 || rx_err === 1'b1) begin
      if (sb_q.size() == 0) begin
        vec_count++;
        miscompares++;
        $display("FAIL rx_unexpected: valid=%0b err=%0b data=%0h, expected no pulse",
                 rx_valid, rx_err, rx_data);
      end else begin
        e = sb_q.pop_front();
        chk("rx_err_flag", 32'(rx_err), 32'(e.err));
        chk("rx_valid_flag", 32'(rx_valid), 32'(!e.err));
        chk("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 8'h81};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h81};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF};

    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_idle", 32'(rx_idle), 32'd1);

    // Table-driven RX frames.
    for (int v = 0; v < 6; v++) begin
      sb_q.push_back('{err: vecs[v].err, data: vecs[v].exp_data});
      send_rx(vecs[v].data, vecs[v].stop);
      repeat (2 * Cpb) tick();
      chk("rx_vec_drain", 32'(sb_q.size()), 32'd0);
      chk("rx_vec_idle", 32'(rx_idle), 32'd1);
    end

    // 3-cycle glitch must be rejected and RX return to IDLE.
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    chk("glitch_left_idle", 32'(rx_idle), 32'd0);
    n = 0;
    while (!rx_idle && n < 12) begin tick(); n++; end
    chk("glitch_idle_again", 32'(rx_idle), 32'd1);
    repeat (Cpb) tick();
    chk("glitch_no_pulse", 32'(sb_q.size()), 32'd0);

    // Low stop bit with the line held low: one error pulse, RX stays busy.
    sb_q.push_back('{err: 1'b1, data: 8'hFF});
    rx_drv = 1'b0;
    repeat (12 * Cpb) tick();
    chk("brk_err_seen", 32'(sb_q.size()), 32'd0);
    chk("brk_not_idle", 32'(rx_idle), 32'd0);
    rx_drv = 1'b1;
    repeat (4) tick();
    chk("brk_idle_after_high", 32'(rx_idle), 32'd1);

    // TX waveform for 8'hA5.
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    chk("a5_ready_before", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 160; k++) begin
      logic [7:0] a5;
      logic       exp_line;
      a5 = 8'hA5;
      if (k < Cpb)           exp_line = 1'b0;
      else if (k < 9 * Cpb)  exp_line = a5[k / Cpb - 1];
      else                   exp_line = 1'b1;
      chk("a5_line", 32'(uart_tx), 32'(exp_line));
      chk("a5_ready", 32'(tx_ready), 32'(k == 159));
      tick();
    end
    chk("a5_line_after", 32'(uart_tx), 32'd1);

    // Loopback, back-to-back 8'hFF then 8'h01.
    loop_en = 1'b1;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 400) begin tick(); n++; end
    chk("b2b_first_ready", 32'(tx_ready), 32'd1);
    sb_q.push_back('{err: 1'b0, data: 8'hFF});
    tick();
    tx_data = 8'h01;
    n = 0;
    while (!tx_ready && n < 400) begin tick(); n++; end
    chk("b2b_gap", 32'(n), 32'd159);
    sb_q.push_back('{err: 1'b0, data: 8'h01});
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin tick(); n++; end
    chk("b2b_drain", 32'(sb_q.size()), 32'd0);
    n = 0;
    while (!tx_idle && n < 400) begin tick(); n++; end
    repeat (Cpb) tick();
    loop_en = 1'b0;

    // Reset during data bit 4 of a TX frame.
    tx_data = 8'h00;
    tx_valid = 1'b1;
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    repeat (5 * Cpb + 8) tick();
    chk("rst_mid_line_low", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_line_high", 32'(uart_tx), 32'd1);
    chk("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_mid_tx_idle", 32'(tx_idle), 32'd1);
    chk("rst_mid_rx_idle", 32'(rx_idle), 32'd1);
    chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_rx_err", 32'(rx_err), 32'd0);
    chk("rst_mid_rx_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    repeat (2 * Cpb) tick();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
